// File: rtl/button_debounce_pulse_pkg.sv
// Shared definitions for the push-button conditioning path: debounce state
// encodings and the stability-count defaults for simulation and the board.
package button_debounce_pulse_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'b00,
    WAIT_HIGH = 2'b01,
    IDLE_HIGH = 2'b11,
    WAIT_LOW  = 2'b10
  } state_t;

  localparam int STABLE_COUNT_SIM   = 4;
  localparam int STABLE_COUNT_BOARD = 1000000;

endpackage

// File: rtl/button_debounce_pulse_sync_chain.sv
// Flip-flop synchronizer chain for asynchronous single-bit inputs (buttons,
// switches). o_q is the last stage; the chain clears on synchronous reset.
module button_debounce_pulse_sync_chain #(
  parameter int STAGES = 2
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/button_debounce_pulse.sv
// Synchronizes and debounces a raw push-button, producing a clean level plus
// single-cycle press and release pulses. FSM state and counter are exported.
module button_debounce_pulse
  import button_debounce_pulse_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int STABLE_COUNT = STABLE_COUNT_BOARD,
  parameter int CNT_WIDTH    = $clog2(STABLE_COUNT)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 button_in,
  output logic                 level_out,
  output logic                 press_pulse,
  output logic                 release_pulse,
  output state_t               dbg_state,
  output logic [CNT_WIDTH-1:0] dbg_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_TERM = CNT_WIDTH'(STABLE_COUNT - 1);

  logic                 w_s;
  state_t               r_state;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_level;
  logic                 r_press;
  logic                 r_release;

  button_debounce_pulse_sync_chain #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .i_clock(clock),
    .i_reset(reset),
    .i_d    (button_in),
    .o_q    (w_s)
  );

  // Pulses default low every cycle, so each one lasts exactly one clock.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE_LOW;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_press   <= 1'b0;
      r_release <= 1'b0;
      case (r_state)
        IDLE_LOW: begin
          if (w_s) begin
            r_state <= WAIT_HIGH;
            r_cnt   <= CNT_ONE;
          end
        end
        WAIT_HIGH: begin
          if (!w_s) begin
            r_state <= IDLE_LOW;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_TERM) begin
            r_state <= IDLE_HIGH;
            r_cnt   <= '0;
            r_level <= 1'b1;
            r_press <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        IDLE_HIGH: begin
          if (!w_s) begin
            r_state <= WAIT_LOW;
            r_cnt   <= CNT_ONE;
          end
        end
        WAIT_LOW: begin
          if (w_s) begin
            r_state <= IDLE_HIGH;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_TERM) begin
            r_state   <= IDLE_LOW;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_release <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        default: begin
          r_state <= IDLE_LOW;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign level_out     = r_level;
  assign press_pulse   = r_press;
  assign release_pulse = r_release;
  assign dbg_state     = r_state;
  assign dbg_count     = r_cnt;

endmodule

// File: tb/tb_button_debounce_pulse.sv
// Bench for button_debounce_pulse: directed press/release/bounce/glitch/reset
// scenarios plus random button runs, checked each cycle against a run-length model.
module tb_button_debounce_pulse;
  import button_debounce_pulse_pkg::*;

  localparam int SYNC  = 2;
  localparam int STAB  = STABLE_COUNT_SIM;
  localparam int CW    = $clog2(STAB);

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic button_in = 1'b0;
  always #5 clock = ~clock;

  logic          level_out, press_pulse, release_pulse;
  state_t        dbg_state;
  logic [CW-1:0] dbg_count;

  button_debounce_pulse #(
    .SYNC_STAGES (SYNC),
    .STABLE_COUNT(STAB)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .button_in    (button_in),
    .level_out    (level_out),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .dbg_state    (dbg_state),
    .dbg_count    (dbg_count)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_press  = 0;
  int n_rel    = 0;
  bit started  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the debouncer only sees the input SYNC edges late; a
  // level change is accepted once STAB consecutive samples differ from it.
  logic m_sync[SYNC] = '{default: 1'b0};
  int   m_run     = 0;
  logic m_level   = 1'b0;
  logic m_press   = 1'b0;
  logic m_release = 1'b0;

  always @(posedge clock) begin
    logic seen;
    m_press   = 1'b0;
    m_release = 1'b0;
    if (reset) begin
      for (int i = 0; i < SYNC; i++) m_sync[i] = 1'b0;
      m_run   = 0;
      m_level = 1'b0;
    end else begin
      seen = m_sync[SYNC-1];
      if (seen != m_level) begin
        m_run++;
        if (m_run == STAB) begin
          m_level = seen;
          m_run   = 0;
          if (seen) m_press = 1'b1;
          else      m_release = 1'b1;
        end
      end else begin
        m_run = 0;
      end
      for (int i = SYNC - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
      m_sync[0] = button_in;
    end
  end

  // Scoreboard: compare every cycle on the falling edge.
  always @(negedge clock) begin
    state_t exp_state;
    if (started) begin
      if (m_level) exp_state = (m_run > 0) ? WAIT_LOW : IDLE_HIGH;
      else         exp_state = (m_run > 0) ? WAIT_HIGH : IDLE_LOW;
      check("level", 32'(level_out), 32'(m_level));
      check("press", 32'(press_pulse), 32'(m_press));
      check("release", 32'(release_pulse), 32'(m_release));
      check("state", 32'(dbg_state), 32'(exp_state));
      check("count", 32'(dbg_count), 32'(m_run));
    end
  end

  // Driver: sample pulses just after the edge, then apply next inputs.
  task automatic drive(input logic b, input logic r);
    @(posedge clock);
    #1;
    if (press_pulse) n_press++;
    if (release_pulse) n_rel++;
    button_in = b;
    reset     = r;
  endtask

  task automatic hold(input logic b, input int n);
    repeat (n) drive(b, 1'b0);
  endtask

  task automatic expect_pulses(input string tag, input int p, input int r);
    check({tag, "_presses"}, 32'(n_press), 32'(p));
    check({tag, "_releases"}, 32'(n_rel), 32'(r));
    n_press = 0;
    n_rel   = 0;
  endtask

  initial begin
    logic bounce[10];
    bounce = '{1, 0, 1, 1, 0, 1, 1, 1, 1, 1};

    // reset held 3 cycles with button high, then released while held
    button_in = 1'b1;
    drive(1'b1, 1'b1);
    started = 1'b1;
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b1);
    expect_pulses("in_reset", 0, 0);
    hold(1'b1, 12);
    expect_pulses("after_reset_held", 1, 0);
    check("after_reset_level", 32'(level_out), 32'd1);

    // clean release
    hold(1'b0, 12);
    expect_pulses("clean_release", 0, 1);
    check("release_level", 32'(level_out), 32'd0);

    // clean press, held 20 cycles (no auto-repeat)
    hold(1'b1, 20);
    expect_pulses("clean_press", 1, 0);
    hold(1'b0, 12);
    expect_pulses("release2", 0, 1);

    // bounce then settle high
    for (int i = 0; i < 10; i++) drive(bounce[i], 1'b0);
    hold(1'b1, 10);
    expect_pulses("bounce", 1, 0);
    hold(1'b0, 12);
    expect_pulses("release3", 0, 1);

    // 3-cycle glitch is rejected
    hold(1'b1, 3);
    hold(1'b0, 10);
    expect_pulses("glitch", 0, 0);
    check("glitch_level", 32'(level_out), 32'd0);

    // reset while waiting high with count 2
    hold(1'b1, 4);
    drive(1'b0, 1'b1);
    check("pre_reset_count", 32'(dbg_count), 32'd2);
    check("pre_reset_state", 32'(dbg_state), 32'(WAIT_HIGH));
    drive(1'b0, 1'b0);
    check("post_reset_state", 32'(dbg_state), 32'(IDLE_LOW));
    check("post_reset_count", 32'(dbg_count), 32'd0);
    hold(1'b0, 10);
    expect_pulses("reset_wait", 0, 0);

    // random runs with occasional resets
    for (int k = 0; k < 120; k++) begin
      logic v;
      int   len;
      v   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 8);
      if ($urandom_range(0, 30) == 0) drive(v, 1'b1);
      hold(v, len);
    end
    hold(1'b0, 12);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
